// File: rtl/rf_pkg.sv
// Shared types and constants for the register file write path.
package rf_pkg;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NREGS = 32;

   typedef logic [AW-1:0] reg_addr_t;
   typedef logic [DW-1:0] reg_data_t;

   localparam reg_addr_t REG_ZERO = '0;

   typedef enum logic [0:0] {
      ARB,
      FORCE
   } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for the mul/div unit plus the decode hazard lookup.
// With RF_WB_FWD_EN defined, a source whose bit is being cleared by the current
// write is not reported, since decode picks the value off the forwarding path.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic          Clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_rd,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_rd,
   input  logic [AW-1:0] dec_rs,
   input  logic [AW-1:0] dec_rt,
   output logic          hazard
);

   logic [NREGS-1:0] sb_q, sb_d;
   logic [NREGS-1:0] set_vec, clr_vec, pend;

   // Next scoreboard: clear the accepted destination, then set the issued one (set wins).
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (set_en && (set_rd != REG_ZERO)) set_vec[set_rd] = 1'b1;
      if (clr_en) clr_vec[clr_rd] = 1'b1;
      sb_d    = (sb_q & ~clr_vec) | set_vec;
      sb_d[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) sb_q <= '0;
      else     sb_q <= sb_d;
   end

   // Hazard lookup for both decode sources.
   always_comb begin
`ifdef RF_WB_FWD_EN
      pend = sb_q & ~clr_vec;
`else
      pend = sb_q;
`endif
      hazard = pend[dec_rs] | pend[dec_rt];
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register file write port between the WB stage (requester 0)
// and the mul/div unit (requester 1), forcing a mul/div grant after STARVE_LIMIT
// consecutive blocked cycles. Optional macro RF_WB_FWD_EN adds a forwarding tap.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic          Clk,
   input  logic          rst,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   input  logic          md_valid,
   input  logic [AW-1:0] md_rd,
   input  logic [DW-1:0] md_data,
   output logic          md_ready,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rd,
   input  logic [AW-1:0] dec_rs,
   input  logic [AW-1:0] dec_rt,
   output logic          hazard,
   output logic          stall_pipe,
   output logic          rf_write,
   output logic [AW-1:0] rf_rd,
   output logic [DW-1:0] rf_data
`ifdef RF_WB_FWD_EN
   ,
   output logic          fwd_a_hit,
   output logic          fwd_b_hit,
   output logic [DW-1:0] fwd_data
`endif
);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             grant_wb, grant_md;

   assign cnt_inc = starve_q + CNT_W'(1);

   // Arbitration, starvation counting and next-state. Grants are held off while
   // rst is high so an in-flight mul/div result is dropped rather than accepted.
   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      grant_wb   = 1'b0;
      grant_md   = 1'b0;
      stall_pipe = 1'b0;
      if (!rst) begin
         unique case (state_q)
            ARB: begin
               if (wb_valid) begin
                  grant_wb = 1'b1;
                  if (md_valid) begin
                     if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
                        state_d  = FORCE;
                        starve_d = '0;
                     end else begin
                        starve_d = cnt_inc;
                     end
                  end else begin
                     starve_d = '0;
                  end
               end else begin
                  grant_md = md_valid;
                  starve_d = '0;
               end
            end
            FORCE: begin
               stall_pipe = 1'b1;
               grant_md   = md_valid;
               starve_d   = '0;
               state_d    = ARB;
            end
            default: state_d = ARB;
         endcase
      end
   end

   // Write port mux; a grant to r0 is still a grant but never writes.
   always_comb begin
      md_ready = grant_md;
      rf_rd    = grant_md ? md_rd   : wb_rd;
      rf_data  = grant_md ? md_data : wb_data;
      rf_write = (grant_wb | grant_md) & (rf_rd != REG_ZERO);
   end

   // FSM state and starvation counter.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   rf_scoreboard u_scoreboard (
      .Clk    (Clk),
      .rst    (rst),
      .set_en (issue_valid),
      .set_rd (issue_rd),
      .clr_en (grant_md),
      .clr_rd (md_rd),
      .dec_rs (dec_rs),
      .dec_rt (dec_rt),
      .hazard (hazard)
   );

`ifdef RF_WB_FWD_EN
   // Forwarding of the value being written this cycle.
   always_comb begin
      fwd_a_hit = rf_write & (rf_rd == dec_rs);
      fwd_b_hit = rf_write & (rf_rd == dec_rt);
      fwd_data  = rf_data;
   end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; define RF_WB_FWD_EN to cover the forwarding build.
module tb_rf_write_arbiter;
   import rf_pkg::*;

   logic          Clk = 1'b0;
   logic          rst;
   logic          wb_valid, md_valid, issue_valid;
   logic [AW-1:0] wb_rd, md_rd, issue_rd, dec_rs, dec_rt, rf_rd;
   logic [DW-1:0] wb_data, md_data, rf_data;
   logic          md_ready, hazard, stall_pipe, rf_write;
`ifdef RF_WB_FWD_EN
   logic          fwd_a_hit, fwd_b_hit;
   logic [DW-1:0] fwd_data;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   rf_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .Clk         (Clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .md_valid    (md_valid),
      .md_rd       (md_rd),
      .md_data     (md_data),
      .md_ready    (md_ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .dec_rs      (dec_rs),
      .dec_rt      (dec_rt),
      .hazard      (hazard),
      .stall_pipe  (stall_pipe),
      .rf_write    (rf_write),
      .rf_rd       (rf_rd),
      .rf_data     (rf_data)
`ifdef RF_WB_FWD_EN
      ,
      .fwd_a_hit   (fwd_a_hit),
      .fwd_b_hit   (fwd_b_hit),
      .fwd_data    (fwd_data)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      wb_valid = 0; wb_rd = '0; wb_data = '0;
      md_valid = 0; md_rd = '0; md_data = '0;
      issue_valid = 0; issue_rd = '0; dec_rs = '0; dec_rt = '0;
      #2;
      chk("rst_md_ready", md_ready, 0);
      chk("rst_stall", stall_pipe, 0);
      chk("rst_hazard", hazard, 0);
      chk("rst_rf_write", rf_write, 0);
      md_valid = 1; md_rd = 5'd7; #1;
      chk("rst_md_drop", md_ready, 0);
      md_valid = 0;
      step(); step();
      rst = 1'b0;
      step();

      // Lone mul/div request.
      md_valid = 1; md_rd = 5'd7; md_data = 32'hDEADBEEF; #1;
      chk("lone_md_ready", md_ready, 1);
      chk("lone_rf_write", rf_write, 1);
      chk("lone_rf_rd", rf_rd, 7);
      chk("lone_rf_data", rf_data, 32'hDEADBEEF);
      step();

      // Contention: WB wins for four cycles, then FORCE.
      wb_valid = 1; wb_rd = 5'd3; wb_data = 32'd5;
      md_valid = 1; md_rd = 5'd9; md_data = 32'h99;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_rf_rd", rf_rd, 3);
         chk("cont_md_ready", md_ready, 0);
         chk("cont_stall", stall_pipe, 0);
         step();
      end
      #1;
      chk("force_stall", stall_pipe, 1);
      chk("force_rf_rd", rf_rd, 9);
      chk("force_rf_data", rf_data, 32'h99);
      chk("force_md_ready", md_ready, 1);
      chk("force_rf_write", rf_write, 1);
      step();
      #1;
      chk("resume_stall", stall_pipe, 0);
      chk("resume_rf_rd", rf_rd, 3);
      chk("resume_rf_data", rf_data, 5);
      chk("resume_md_ready", md_ready, 0);
      wb_valid = 0; md_valid = 0;
      step();

      // Scoreboard set, lookup, clear.
      issue_valid = 1; issue_rd = 5'd12; dec_rs = 5'd12; dec_rt = 5'd0; #1;
      chk("sb_before_set", hazard, 0);
      step();
      issue_valid = 0; #1;
      chk("sb_set_rs", hazard, 1);
      dec_rs = 5'd0; dec_rt = 5'd12; #1;
      chk("sb_set_rt", hazard, 1);
      dec_rs = 5'd12; dec_rt = 5'd0;
      md_valid = 1; md_rd = 5'd12; md_data = 32'h1234; #1;
`ifdef RF_WB_FWD_EN
      chk("sb_clear_masked", hazard, 0);
      chk("fwd_a_md", fwd_a_hit, 1);
      chk("fwd_data_md", fwd_data, 32'h1234);
`else
      chk("sb_clear_same_cycle", hazard, 1);
`endif
      step();
      md_valid = 0; #1;
      chk("sb_cleared", hazard, 0);

      // Issue and commit to the same register: set wins.
      issue_valid = 1; issue_rd = 5'd12; md_valid = 1; md_rd = 5'd12; #1;
      chk("sb_both_ready", md_ready, 1);
      step();
      issue_valid = 0; md_valid = 0; #1;
      chk("sb_set_wins", hazard, 1);
      md_valid = 1; md_rd = 5'd12;
      step();
      md_valid = 0; #1;
      chk("sb_cleared2", hazard, 0);

      // Register zero: grant without write; r0 never pending.
      md_valid = 1; md_rd = 5'd0; md_data = 32'd1;
      issue_valid = 1; issue_rd = 5'd0; dec_rs = 5'd0; dec_rt = 5'd0; #1;
      chk("r0_rf_write", rf_write, 0);
      chk("r0_md_ready", md_ready, 1);
      step();
      md_valid = 0; issue_valid = 0; #1;
      chk("r0_hazard", hazard, 0);

`ifdef RF_WB_FWD_EN
      wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hCAFE; dec_rs = 5'd5; dec_rt = 5'd6; #1;
      chk("fwd_a_hit", fwd_a_hit, 1);
      chk("fwd_b_hit", fwd_b_hit, 0);
      chk("fwd_data", fwd_data, 32'hCAFE);
      wb_valid = 0;
      step();
`endif

      // Reset while in FORCE with r4 pending.
      issue_valid = 1; issue_rd = 5'd4; dec_rs = 5'd4; dec_rt = 5'd0;
      step();
      issue_valid = 0;
      wb_valid = 1; wb_rd = 5'd3; wb_data = 32'd5;
      md_valid = 1; md_rd = 5'd9; md_data = 32'h99;
      for (int i = 0; i < 4; i++) step();
      #1;
      chk("pre_rst_stall", stall_pipe, 1);
      chk("pre_rst_hazard", hazard, 1);
      rst = 1'b1; #1;
      chk("mid_rst_stall", stall_pipe, 0);
      chk("mid_rst_hazard", hazard, 0);
      chk("mid_rst_md_ready", md_ready, 0);
      chk("mid_rst_rf_write", rf_write, 0);
      #1;
      rst = 1'b0;
      step();
      #1;
      chk("post_rst_stall", stall_pipe, 0);
      chk("post_rst_rf_rd", rf_rd, 3);
      chk("post_rst_md_ready", md_ready, 0);
      chk("post_rst_hazard", hazard, 0);
      wb_valid = 0; md_valid = 0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
